// File: rtl/score_digits_ctrl.sv
// score_digits_ctrl
//   Keeps the game score as NUM_DIGITS BCD digits and feeds the digit bitmap stage
//   for a horizontal row of digit cells.
//   Additions ripple one digit per cycle through a work copy of the score. The
//   display copy, which is the only copy the pixel path reads, changes only when
//   an addition commits or the score is cleared. A carry out of the top digit
//   saturates the score to all 9s and sets a sticky overflow flag.
//
// Ports
//   clk             clock
//   resetN          synchronous reset, active-high
//   pixelX/pixelY   current pixel coordinates
//   add_valid       request to add add_value (BCD units, clamped to 9)
//   add_value       value to add
//   add_ready       request accepted when add_valid & add_ready
//   clear_score     zero score and overflow; wins over everything else
//   offsetX/offsetY position inside the current digit cell (registered)
//   InsideRectangle pixel lies in a drawn digit cell (registered)
//   digit           committed BCD digit for the current cell (registered)
//   score_bcd       committed score, digit 0 in bits [3:0]
//   overflow        sticky saturation flag
module score_digits_ctrl #(
  parameter int NUM_DIGITS    = 4,
  parameter int DIGIT_W       = 16,
  parameter int DIGIT_H       = 32,
  parameter int TOP_LEFT_X    = 20,
  parameter int TOP_LEFT_Y    = 20,
  parameter int LEADING_BLANK = 1
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic [10:0]             pixelX,
  input  logic [10:0]             pixelY,
  input  logic                    add_valid,
  input  logic [3:0]              add_value,
  output logic                    add_ready,
  input  logic                    clear_score,
  output logic [10:0]             offsetX,
  output logic [10:0]             offsetY,
  output logic                    InsideRectangle,
  output logic [3:0]              digit,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic                    overflow
);

  localparam int             IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam int             COL_SHIFT = $clog2(DIGIT_W);
  localparam int             ROW_W     = NUM_DIGITS * DIGIT_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ADD    = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] idx;
  logic [3:0]       cin;          // clamped add_value on the first ADD cycle, then 0/1 carry
  logic [3:0]       work    [NUM_DIGITS];
  logic [3:0]       display [NUM_DIGITS];

  logic [3:0]       add_clamped;
  logic [4:0]       sum;
  logic             carry;
  logic [3:0]       sum_digit;

  assign add_clamped = (add_value > 4'd9) ? 4'd9 : add_value;

  // ---------------------------------------------------------------------------
  // Control: next state, handshake and the single-digit BCD adder
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no
    // path can leave one unassigned and infer a latch.
    state_next = state;
    add_ready  = 1'b0;
    sum        = 5'(work[idx]) + 5'(cin);
    carry      = (sum > 5'd9);
    sum_digit  = carry ? 4'(sum - 5'd10) : sum[3:0];

    unique case (state)
      S_IDLE: begin
        // Held low while reset is asserted so no request is taken during reset.
        add_ready = ~clear_score & ~resetN;
        if (add_valid && add_ready) state_next = S_ADD;
      end
      // Always walks every digit; a carry may appear at any position.
      S_ADD:    if (idx == LAST_IDX) state_next = S_COMMIT;
      S_COMMIT: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase

    if (clear_score) state_next = S_IDLE;
  end

  // ---------------------------------------------------------------------------
  // State register and score datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here samples the values from before this clock edge.
    if (resetN) begin
      state    <= S_IDLE;
      idx      <= '0;
      cin      <= '0;
      overflow <= 1'b0;
      // NOTE: the digit arrays are a handful of flops, not a RAM, and the score
      // must read zero straight out of reset, so they are reset explicitly.
      for (int k = 0; k < NUM_DIGITS; k++) begin
        work[k]    <= 4'd0;
        display[k] <= 4'd0;
      end
    end else begin
      state <= state_next;
      if (clear_score) begin
        idx      <= '0;
        cin      <= '0;
        overflow <= 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
          work[k]    <= 4'd0;
          display[k] <= 4'd0;
        end
      end else begin
        unique case (state)
          S_IDLE: begin
            if (add_valid && add_ready) begin
              cin <= add_clamped;
              idx <= '0;
            end
          end
          S_ADD: begin
            work[idx] <= sum_digit;
            cin       <= {3'b000, carry};
            idx       <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
          end
          S_COMMIT: begin
            // cin now holds the carry out of the most significant digit.
            if (cin[0]) begin
              overflow <= 1'b1;
              for (int k = 0; k < NUM_DIGITS; k++) begin
                work[k]    <= 4'd9;
                display[k] <= 4'd9;
              end
            end else begin
              for (int k = 0; k < NUM_DIGITS; k++) display[k] <= work[k];
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    score_bcd = '0;
    for (int k = 0; k < NUM_DIGITS; k++) score_bcd[4*k +: 4] = display[k];
  end

  // ---------------------------------------------------------------------------
  // Pixel path: one registered stage, reads the display copy only
  // ---------------------------------------------------------------------------
  logic [10:0] rx, ry, col;
  logic        in_row;
  logic        zero_from;   // display digits k..NUM_DIGITS-1 are all zero
  logic [3:0]  sel_digit;
  logic        sel_blank;

  always_comb begin
    // Unsigned wrap: pixels left of or above the origin become huge and fail
    // the range compare.
    rx        = pixelX - 11'(TOP_LEFT_X);
    ry        = pixelY - 11'(TOP_LEFT_Y);
    in_row    = (rx < 11'(ROW_W)) && (ry < 11'(DIGIT_H));
    col       = rx >> COL_SHIFT;
    zero_from = 1'b1;
    sel_digit = 4'd0;
    sel_blank = 1'b0;
    // Walk from the most significant digit so zero_from accumulates the
    // "all higher digits are zero" condition used for leading blanking.
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_from = zero_from & (display[k] == 4'd0);
      if (col == 11'(NUM_DIGITS - 1 - k)) begin
        sel_digit = display[k];
        sel_blank = (LEADING_BLANK != 0) && (k != 0) && zero_from;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      offsetX         <= '0;
      offsetY         <= '0;
      InsideRectangle <= 1'b0;
      digit           <= 4'd0;
    end else if (in_row) begin
      offsetX         <= rx & 11'(DIGIT_W - 1);
      offsetY         <= ry;
      InsideRectangle <= ~sel_blank;
      digit           <= sel_digit;
    end else begin
      offsetX         <= '0;
      offsetY         <= '0;
      InsideRectangle <= 1'b0;
      digit           <= 4'd0;
    end
  end

endmodule

// File: tb/tb_score_digits_ctrl.sv
// tb_score_digits_ctrl
//   Self-checking bench for score_digits_ctrl with default parameters. The
//   reference keeps the score as a plain integer 0..9999 plus an overflow bit;
//   BCD digits, cell selection and blanking are derived from it arithmetically.
module tb_score_digits_ctrl;

  logic        clk = 1'b0;
  logic        resetN;
  logic [10:0] pixelX, pixelY;
  logic        add_valid;
  logic [3:0]  add_value;
  logic        add_ready;
  logic        clear_score;
  logic [10:0] offsetX, offsetY;
  logic        InsideRectangle;
  logic [3:0]  digit;
  logic [15:0] score_bcd;
  logic        overflow;

  score_digits_ctrl dut (
    .clk             (clk),
    .resetN          (resetN),
    .pixelX          (pixelX),
    .pixelY          (pixelY),
    .add_valid       (add_valid),
    .add_value       (add_value),
    .add_ready       (add_ready),
    .clear_score     (clear_score),
    .offsetX         (offsetX),
    .offsetY         (offsetY),
    .InsideRectangle (InsideRectangle),
    .digit           (digit),
    .score_bcd       (score_bcd),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int score_m = 0;
  bit ovf_m = 1'b0;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int s);
    logic [15:0] r;
    int p;
    r = '0;
    p = 1;
    for (int k = 0; k < 4; k++) begin
      r[4*k +: 4] = 4'((s / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic int pow10(input int k);
    int p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  // One complete addition: request, five busy cycles, commit.
  task automatic do_add(input int v, input bit noise);
    logic [15:0] old;
    int c;
    old       = to_bcd(score_m);
    add_value = 4'(v);
    add_valid = 1'b1;
    #1;
    check("ready_idle", 32'(add_ready), 32'd1);
    step();
    add_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (noise) begin
        add_valid = 1'($urandom_range(0, 1));
        add_value = 4'($urandom_range(0, 15));
      end
      #1;
      check("ready_busy", 32'(add_ready), 32'd0);
      check("score_hold", 32'(score_bcd), 32'(old));
      step();
    end
    add_valid = 1'b0;
    c = (v > 9) ? 9 : v;
    score_m = score_m + c;
    if (score_m > 9999) begin
      score_m = 9999;
      ovf_m   = 1'b1;
    end
    #1;
    check("score_commit", 32'(score_bcd), 32'(to_bcd(score_m)));
    check("overflow", 32'(overflow), 32'(ovf_m));
    check("ready_after", 32'(add_ready), 32'd1);
  endtask

  task automatic reach(input int target);
    while (score_m + 9 <= target) do_add(9, 1'b0);
    if (target > score_m) do_add(target - score_m, 1'b0);
  endtask

  task automatic do_clear();
    clear_score = 1'b1;
    add_valid   = 1'b1;
    add_value   = 4'd3;
    #1;
    check("ready_clear", 32'(add_ready), 32'd0);
    step();
    clear_score = 1'b0;
    add_valid   = 1'b0;
    score_m     = 0;
    ovf_m       = 1'b0;
    #1;
    check("clear_score", 32'(score_bcd), 32'd0);
    check("clear_ovf", 32'(overflow), 32'd0);
    check("clear_ready", 32'(add_ready), 32'd1);
  endtask

  task automatic check_pixel(input int px, input int py);
    int rx, ry, k;
    logic [10:0] e_ox, e_oy;
    logic        e_in;
    logic [3:0]  e_dig;
    pixelX = 11'(px);
    pixelY = 11'(py);
    step();
    rx = px - 20;
    ry = py - 20;
    e_ox = '0; e_oy = '0; e_in = 1'b0; e_dig = '0;
    if (rx >= 0 && rx < 64 && ry >= 0 && ry < 32) begin
      k     = 3 - rx / 16;
      e_ox  = 11'(rx % 16);
      e_oy  = 11'(ry);
      e_dig = 4'((score_m / pow10(k)) % 10);
      e_in  = !(k != 0 && score_m < pow10(k));
    end
    check("pix_inside", 32'(InsideRectangle), 32'(e_in));
    check("pix_offx", 32'(offsetX), 32'(e_ox));
    check("pix_offy", 32'(offsetY), 32'(e_oy));
    check("pix_digit", 32'(digit), 32'(e_dig));
  endtask

  task automatic random_pixels(input int n);
    for (int i = 0; i < n; i++) check_pixel($urandom_range(0, 110), $urandom_range(0, 70));
  endtask

  initial begin
    resetN      = 1'b1;
    pixelX      = 11'd0;
    pixelY      = 11'd0;
    add_valid   = 1'b0;
    add_value   = 4'd0;
    clear_score = 1'b0;
    step();
    step();
    check("rst_ready", 32'(add_ready), 32'd0);
    check("rst_score", 32'(score_bcd), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_inside", 32'(InsideRectangle), 32'd0);
    check("rst_digit", 32'(digit), 32'd0);
    resetN = 1'b0;
    #1;
    check("ready_out_of_reset", 32'(add_ready), 32'd1);

    // Score 0: rightmost cell drawn, others blanked, corners of the row.
    check_pixel(20 + 3*16 + 5, 20 + 7);
    check_pixel(19, 20);
    check_pixel(20, 19);
    check_pixel(20, 20);
    check_pixel(83, 51);
    check_pixel(84, 51);
    check_pixel(83, 52);

    // Clamp and ignored requests while busy.
    do_add(12, 1'b1);
    step();
    check("no_queued_add", 32'(score_bcd), 32'h0009);
    do_clear();

    // 0099 + 1 ripples two carries.
    reach(99);
    do_add(1, 1'b0);
    check("score_0100", 32'(score_bcd), 32'h0100);
    random_pixels(10);
    do_clear();

    // Leading blanking with score 42.
    reach(42);
    check_pixel(20 + 0*16 + 3, 25);
    check_pixel(20 + 1*16 + 3, 25);
    check_pixel(20 + 2*16 + 3, 25);
    check_pixel(20 + 3*16 + 3, 25);
    do_clear();
    for (int c = 0; c < 4; c++) check_pixel(20 + c*16 + 8, 30);

    // Saturation at the top digit.
    reach(9995);
    do_add(7, 1'b0);
    check("score_sat", 32'(score_bcd), 32'h9999);
    check("ovf_set", 32'(overflow), 32'd1);
    do_add(1, 1'b0);
    check_pixel(30, 30);
    do_clear();

    // Randomized additions with interleaved pixel checks.
    for (int i = 0; i < 60; i++) begin
      do_add($urandom_range(0, 15), 1'($urandom_range(0, 1)));
      if (i % 6 == 0) random_pixels(3);
    end

    // Clear in the middle of an addition with a same-cycle request.
    check("pre_clear_nonzero", 32'(score_bcd == 16'h0000), 32'(score_m == 0));
    add_value = 4'd5;
    add_valid = 1'b1;
    step();
    add_valid = 1'b0;
    step();
    step();
    do_clear();
    for (int i = 0; i < 6; i++) begin
      step();
      check("no_pending_score", 32'(score_bcd), 32'd0);
      check("no_pending_ready", 32'(add_ready), 32'd1);
    end
    do_add(3, 1'b0);

    // Reset in the middle of an addition.
    reach(500);
    add_value = 4'd4;
    add_valid = 1'b1;
    step();
    add_valid = 1'b0;
    step();
    resetN = 1'b1;
    pixelX = 11'd70;
    pixelY = 11'd25;
    step();
    check("mid_rst_ready", 32'(add_ready), 32'd0);
    check("mid_rst_score", 32'(score_bcd), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    check("mid_rst_inside", 32'(InsideRectangle), 32'd0);
    check("mid_rst_offx", 32'(offsetX), 32'd0);
    check("mid_rst_digit", 32'(digit), 32'd0);
    resetN  = 1'b0;
    score_m = 0;
    ovf_m   = 1'b0;
    #1;
    check("post_rst_ready", 32'(add_ready), 32'd1);
    do_add(2, 1'b0);
    check_pixel(70, 25);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
